// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity,
// one or two stop bits, one serial bit per CLK with all outputs registered.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_BIT,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic [2:0]            STATE_DBG
);

    localparam int CNT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    // Encoding is visible on STATE_DBG: IDLE=0 START=1 DATA=2 PARITY=3 STOP=4.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Handshake: DATA_VALID is taken only in IDLE; BUSY is the host's ready-low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The bit counter is shared between DATA and STOP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) begin
                    state_d  = S_START;
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
                cnt_d   = '0;
            end
            S_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = (state_q == S_STOP);
            end
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[cnt_d];
            S_PARITY: tx_d = PAR_BIT;
            S_STOP:   tx_d = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign TX_OUT     = tx_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign STATE_DBG  = state_q;

endmodule
